// File: rtl/memory_stage.sv
// memory_stage: M pipeline stage with a word-organised, byte-lane-writable data memory (build option MEM_ALIGN_CHECK_EN).
// Latency: DM read is combinational in M, and every out_* (including extended load data) is registered, so results appear 1 clk later.
// Backpressure: none; the stage advances on every rising edge, with no stall or enable.
module memory_stage #(
   parameter int DM_WORDS = 3072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_PC,
   input  logic [31:0] in_instruction,
   input  logic [31:0] in_ALUout,
   input  logic [31:0] in_HI_LO,
   input  logic [31:0] in_Shift,
   input  logic [31:0] in_rt_data,
   input  logic        in_bw,
   input  logic [1:0]  in_store_type,
   input  logic [2:0]  in_load_type,
   output logic [31:0] out_PC,
   output logic [31:0] out_instruction,
   output logic [31:0] out_ALUout,
   output logic [31:0] out_HI_LO,
   output logic [31:0] out_Shift,
   output logic [31:0] out_DMout,
   output logic        out_bw,
   output logic        out_align_err
);

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_SW   = 2'd1;
   localparam logic [1:0] ST_SH   = 2'd2;
   localparam logic [1:0] ST_SB   = 2'd3;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LBU  = 3'd2;
   localparam logic [2:0] LD_LH   = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;

   logic [31:0] dm_q [DM_WORDS];

   logic [11:0] word_idx;
   logic [1:0]  a;
   logic        in_range;
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] wr_mask;
   logic [31:0] wr_data;
   logic [31:0] merged;
   logic        wr_en;
   logic        align_err_d;
   logic [31:0] dm_out_d;

   logic [31:0] pc_q, instr_q, alu_q, hilo_q, shift_q, dm_out_q;
   logic        bw_q, align_err_q;

   // Address decode: bits above 13 are ignored, indices past the array end read as 0 and never write.
   assign word_idx = in_ALUout[13:2];
   assign a        = in_ALUout[1:0];
   assign in_range = ({20'd0, word_idx} < 32'(DM_WORDS));
   assign rd_word  = in_range ? dm_q[word_idx] : 32'd0;

   // Lane selection for sub-word loads (little-endian).
   always_comb begin
      rd_byte = rd_word[7:0];
      case (a)
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         2'd3:    rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      rd_half = a[1] ? rd_word[31:16] : rd_word[15:0];
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic is_load;
   logic lw_class;
   logic st_mis;
   logic ld_mis;

   // Misalignment trap; loads are recognised by the MIPS load opcode group (100xxx) since load_type alone defaults to lw.
   always_comb begin
      is_load     = (in_instruction[31:29] == 3'b100) && (in_store_type == ST_NONE);
      lw_class    = !(in_load_type inside {LD_LB, LD_LBU, LD_LH, LD_LHU});
      st_mis      = ((in_store_type == ST_SW) && (a != 2'd0)) ||
                    ((in_store_type == ST_SH) && a[0]);
      ld_mis      = is_load && ((lw_class && (a != 2'd0)) ||
                    (((in_load_type == LD_LH) || (in_load_type == LD_LHU)) && a[0]));
      align_err_d = st_mis || ld_mis;
   end
`else
   // Without the check, low address bits only steer byte/half lanes.
   assign align_err_d = 1'b0;
`endif

   // Store byte-enable mask and lane-replicated data for the read-modify-write merge.
   always_comb begin
      wr_mask = 32'd0;
      wr_data = 32'd0;
      case (in_store_type)
         ST_SW: begin
            wr_mask = 32'hFFFF_FFFF;
            wr_data = in_rt_data;
         end
         ST_SH: begin
            wr_mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wr_data = {2{in_rt_data[15:0]}};
         end
         ST_SB: begin
            wr_mask = 32'h0000_00FF << {a, 3'b000};
            wr_data = {4{in_rt_data[7:0]}};
         end
         default: begin
            wr_mask = 32'd0;
            wr_data = 32'd0;
         end
      endcase
   end

   assign merged = (rd_word & ~wr_mask) | (wr_data & wr_mask);
   assign wr_en  = (in_store_type != ST_NONE) && in_range && !align_err_d;

   // Load extension; a trapped access returns 0.
   always_comb begin
      dm_out_d = rd_word;
      case (in_load_type)
         LD_LB:   dm_out_d = {{24{rd_byte[7]}}, rd_byte};
         LD_LBU:  dm_out_d = {24'd0, rd_byte};
         LD_LH:   dm_out_d = {{16{rd_half[15]}}, rd_half};
         LD_LHU:  dm_out_d = {16'd0, rd_half};
         default: dm_out_d = rd_word;
      endcase
      if (align_err_d) begin
         dm_out_d = 32'd0;
      end
   end

   // Data memory: reset clears every word and drops any store presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) begin
            dm_q[i] <= 32'd0;
         end
      end else if (wr_en) begin
         dm_q[word_idx] <= merged;
      end
   end

   // M/W pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= 32'd0;
         instr_q     <= 32'd0;
         alu_q       <= 32'd0;
         hilo_q      <= 32'd0;
         shift_q     <= 32'd0;
         dm_out_q    <= 32'd0;
         bw_q        <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         pc_q        <= in_PC;
         instr_q     <= in_instruction;
         alu_q       <= in_ALUout;
         hilo_q      <= in_HI_LO;
         shift_q     <= in_Shift;
         dm_out_q    <= dm_out_d;
         bw_q        <= in_bw;
         align_err_q <= align_err_d;
      end
   end

   assign out_PC          = pc_q;
   assign out_instruction = instr_q;
   assign out_ALUout      = alu_q;
   assign out_HI_LO       = hilo_q;
   assign out_Shift       = shift_q;
   assign out_DMout       = dm_out_q;
   assign out_bw          = bw_q;
   assign out_align_err   = align_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed test of memory_stage loads, stores, range, alignment and reset.
// Latency: each op is applied for one clock and outputs are sampled 1 time unit after that edge.
// Backpressure: none; the DUT consumes one op per clock.
module tb_memory_stage;

   logic        clk;
   logic        reset;
   logic [31:0] in_PC, in_instruction, in_ALUout, in_HI_LO, in_Shift, in_rt_data;
   logic        in_bw;
   logic [1:0]  in_store_type;
   logic [2:0]  in_load_type;
   logic [31:0] out_PC, out_instruction, out_ALUout, out_HI_LO, out_Shift, out_DMout;
   logic        out_bw, out_align_err;

   int n_vec;
   int n_err;

   memory_stage #(.DM_WORDS(3072)) dut (
      .clk(clk), .reset(reset),
      .in_PC(in_PC), .in_instruction(in_instruction), .in_ALUout(in_ALUout),
      .in_HI_LO(in_HI_LO), .in_Shift(in_Shift), .in_rt_data(in_rt_data),
      .in_bw(in_bw), .in_store_type(in_store_type), .in_load_type(in_load_type),
      .out_PC(out_PC), .out_instruction(out_instruction), .out_ALUout(out_ALUout),
      .out_HI_LO(out_HI_LO), .out_Shift(out_Shift), .out_DMout(out_DMout),
      .out_bw(out_bw), .out_align_err(out_align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One M-stage op for one clock; stores use opcode 0xAC.., loads 0x8C.. (load opcode group).
   task automatic op(input logic [1:0] st, input logic [2:0] lt,
                     input logic [31:0] addr, input logic [31:0] data);
      in_store_type  = st;
      in_load_type   = lt;
      in_ALUout      = addr;
      in_rt_data     = data;
      in_instruction = (st != 2'd0) ? 32'hAC00_0000 : 32'h8C00_0000;
      in_PC          = in_PC + 32'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_PC = 32'h0040_0000; in_instruction = 32'hAC00_0000; in_ALUout = 32'h10;
      in_HI_LO = 32'h1111_2222; in_Shift = 32'h3333_4444; in_rt_data = 32'hDEAD_BEEF;
      in_bw = 1'b1; in_store_type = 2'd1; in_load_type = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_vec++;
      if ({out_PC, out_instruction, out_ALUout, out_HI_LO, out_Shift, out_DMout} !== 192'd0) begin
         n_err++;
         $display("FAIL reset_words got %h %h %h %h %h %h exp all 0",
                  out_PC, out_instruction, out_ALUout, out_HI_LO, out_Shift, out_DMout);
      end
      n_vec++;
      if ({out_bw, out_align_err} !== 2'b00) begin
         n_err++; $display("FAIL reset_flags got %b%b exp 00", out_bw, out_align_err);
      end
      reset = 1'b0;
      in_bw = 1'b0;
      op(2'd0, 3'd0, 32'h10, 32'd0);
      n_vec++;
      if (out_DMout !== 32'd0) begin
         n_err++; $display("FAIL reset_store_discard got %h exp 00000000", out_DMout);
      end
   endtask

   task automatic test_passthrough();
      in_PC = 32'h0040_1230; in_instruction = 32'h8C01_0010; in_ALUout = 32'h0000_0040;
      in_HI_LO = 32'hA5A5_5A5A; in_Shift = 32'h0F0F_F0F0; in_rt_data = 32'h0;
      in_bw = 1'b1; in_store_type = 2'd0; in_load_type = 3'd0;
      @(posedge clk); #1;
      n_vec++;
      if (out_PC !== 32'h0040_1230) begin
         n_err++; $display("FAIL pass_pc got %h exp 00401230", out_PC);
      end
      n_vec++;
      if (out_instruction !== 32'h8C01_0010) begin
         n_err++; $display("FAIL pass_instr got %h exp 8c010010", out_instruction);
      end
      n_vec++;
      if (out_ALUout !== 32'h40) begin
         n_err++; $display("FAIL pass_alu got %h exp 00000040", out_ALUout);
      end
      n_vec++;
      if (out_HI_LO !== 32'hA5A5_5A5A) begin
         n_err++; $display("FAIL pass_hilo got %h exp a5a55a5a", out_HI_LO);
      end
      n_vec++;
      if (out_Shift !== 32'h0F0F_F0F0) begin
         n_err++; $display("FAIL pass_shift got %h exp 0f0ff0f0", out_Shift);
      end
      n_vec++;
      if (out_bw !== 1'b1) begin
         n_err++; $display("FAIL pass_bw1 got %b exp 1", out_bw);
      end
      in_bw = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (out_bw !== 1'b0) begin
         n_err++; $display("FAIL pass_bw0 got %b exp 0", out_bw);
      end
   endtask

   task automatic test_sw_lw();
      op(2'd1, 3'd0, 32'h0010, 32'h1234_5678);
      op(2'd0, 3'd0, 32'h0010, 32'h0);
      n_vec++;
      if (out_DMout !== 32'h1234_5678) begin
         n_err++; $display("FAIL sw_lw got %h exp 12345678", out_DMout);
      end
   endtask

   task automatic test_sb();
      logic [2:0]  lt  [3];
      logic [31:0] ad  [3];
      logic [31:0] ex  [3];
      lt[0] = 3'd1; ad[0] = 32'h13; ex[0] = 32'hFFFF_FF80;
      lt[1] = 3'd2; ad[1] = 32'h13; ex[1] = 32'h0000_0080;
      lt[2] = 3'd0; ad[2] = 32'h10; ex[2] = 32'h8034_5678;
      op(2'd3, 3'd0, 32'h0013, 32'hAAAA_AA80);
      for (int i = 0; i < 3; i++) begin
         op(2'd0, lt[i], ad[i], 32'h0);
         n_vec++;
         if (out_DMout !== ex[i]) begin
            n_err++; $display("FAIL sb_load%0d got %h exp %h", i, out_DMout, ex[i]);
         end
      end
   endtask

   task automatic test_sh();
      logic [2:0]  lt  [5];
      logic [31:0] ad  [5];
      logic [31:0] ex  [5];
      lt[0] = 3'd3; ad[0] = 32'h22; ex[0] = 32'hFFFF_BEEF;
      lt[1] = 3'd4; ad[1] = 32'h22; ex[1] = 32'h0000_BEEF;
      lt[2] = 3'd0; ad[2] = 32'h20; ex[2] = 32'hBEEF_0000;
      lt[3] = 3'd1; ad[3] = 32'h23; ex[3] = 32'hFFFF_FFBE;
      lt[4] = 3'd2; ad[4] = 32'h22; ex[4] = 32'h0000_00EF;
      op(2'd2, 3'd0, 32'h0022, 32'h1234_BEEF);
      for (int i = 0; i < 5; i++) begin
         op(2'd0, lt[i], ad[i], 32'h0);
         n_vec++;
         if (out_DMout !== ex[i]) begin
            n_err++; $display("FAIL sh_load%0d got %h exp %h", i, out_DMout, ex[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      op(2'd1, 3'd0, 32'h3000, 32'hFFFF_FFFF);
      op(2'd0, 3'd0, 32'h3000, 32'h0);
      n_vec++;
      if (out_DMout !== 32'd0) begin
         n_err++; $display("FAIL oor_load got %h exp 00000000", out_DMout);
      end
      op(2'd0, 3'd0, 32'h0000, 32'h0);
      n_vec++;
      if (out_DMout !== 32'd0) begin
         n_err++; $display("FAIL oor_word0 got %h exp 00000000", out_DMout);
      end
      op(2'd1, 3'd0, 32'h2FFC, 32'h1357_9BDF);
      op(2'd0, 3'd0, 32'h2FFC, 32'h0);
      n_vec++;
      if (out_DMout !== 32'h1357_9BDF) begin
         n_err++; $display("FAIL last_word got %h exp 13579bdf", out_DMout);
      end
   endtask

   task automatic test_align();
      logic [31:0] exp_w;
      logic        exp_e;
      logic [31:0] exp_u;
`ifdef MEM_ALIGN_CHECK_EN
      exp_w = 32'h8034_5678; exp_e = 1'b1; exp_u = 32'h0;
`else
      exp_w = 32'hCAFE_F00D; exp_e = 1'b0; exp_u = 32'hCAFE_F00D;
`endif
      op(2'd1, 3'd0, 32'h0012, 32'hCAFE_F00D);
      n_vec++;
      if (out_align_err !== exp_e) begin
         n_err++; $display("FAIL align_sw_err got %b exp %b", out_align_err, exp_e);
      end
      op(2'd0, 3'd0, 32'h0010, 32'h0);
      n_vec++;
      if (out_DMout !== exp_w) begin
         n_err++; $display("FAIL align_word got %h exp %h", out_DMout, exp_w);
      end
      n_vec++;
      if (out_align_err !== 1'b0) begin
         n_err++; $display("FAIL align_err_clear got %b exp 0", out_align_err);
      end
      op(2'd0, 3'd0, 32'h0013, 32'h0);
      n_vec++;
      if (out_DMout !== exp_u || out_align_err !== exp_e) begin
         n_err++; $display("FAIL align_lw got %h/%b exp %h/%b", out_DMout, out_align_err, exp_u, exp_e);
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 5; t < 8; t++) begin
         op(2'd0, 3'(t), 32'h0020, 32'h0);
         n_vec++;
         if (out_DMout !== 32'hBEEF_0000) begin
            n_err++; $display("FAIL lt%0d_as_lw got %h exp beef0000", t, out_DMout);
         end
      end
      op(2'd1, 3'd0, 32'h0024, 32'h8001_7F02);
      op(2'd0, 3'd3, 32'h0026, 32'h0);
      n_vec++;
      if (out_DMout !== 32'hFFFF_8001) begin
         n_err++; $display("FAIL b2b_lh got %h exp ffff8001", out_DMout);
      end
      op(2'd0, 3'd1, 32'h0025, 32'h0);
      n_vec++;
      if (out_DMout !== 32'h0000_007F) begin
         n_err++; $display("FAIL b2b_lb got %h exp 0000007f", out_DMout);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ad [3];
      ad[0] = 32'h10; ad[1] = 32'h20; ad[2] = 32'h40;
      op(2'd1, 3'd0, 32'h0040, 32'h1111_1111);
      reset = 1'b1;
      op(2'd0, 3'd0, 32'h0010, 32'h0);
      n_vec++;
      if ({out_PC, out_ALUout, out_DMout, out_bw, out_align_err} !== 98'd0) begin
         n_err++; $display("FAIL mid_reset_out got pc %h alu %h dm %h exp 0", out_PC, out_ALUout, out_DMout);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         op(2'd0, 3'd0, ad[i], 32'h0);
         n_vec++;
         if (out_DMout !== 32'd0) begin
            n_err++; $display("FAIL mid_reset_dm%0d got %h exp 00000000", i, out_DMout);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_passthrough();
      test_sw_lw();
      test_sb();
      test_sh();
      test_out_of_range();
      test_align();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
